// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment encodings for the multiplexed seven-segment driver
//   bcd_t    : one BCD nibble
//   seg_t    : active-high segment pattern, bit A (0) .. bit G (6)
//   SEG_0..9 : digit encodings; SEG_DASH for non-BCD nibbles; SEG_OFF for blanked digits
package seg7_pkg;
    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;
    localparam int E = 4;
    localparam int F = 5;
    localparam int G = 6;
    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;
endpackage

// File: rtl/bcd7seg.sv
// bcd7seg: combinational BCD nibble to active-high seven-segment pattern
//   d   in  4  BCD nibble
//   seg out 7  segment pattern (a = bit 0); nibbles above 9 show a dash
module bcd7seg
    import seg7_pkg::*;
(
    input  logic [3:0] d,
    output logic [6:0] seg
);
    always_comb begin
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: snapshot a BCD digit bus and time-multiplex it onto one seven-segment display
//   clk      in  1       system clock
//   rst      in  1       asynchronous active-low reset
//   bcd      in  4*NDIG  packed digits, digit 0 in bcd[3:0]
//   load     in  1       samples bcd into the shadow register
//   blank_lz in  1       enables leading-zero blanking
//   seg      out 7       registered segment drive (a = bit 0)
//   an       out NDIG    registered one-hot digit enable
//   frame    out 1       one-cycle pulse after each scan wrap
//   err      out 1       snapshot holds a non-BCD nibble
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int NDIG           = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] bcd,
    input  logic              load,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame,
    output logic              err
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] snap;
    logic [NDIG-1:0]   lz;
    logic              tick, last, bad, run;
    bcd_t              nib;
    seg_t              pat;

    assign tick = cnt == CW'(SCAN_DIV - 1);
    assign last = idx == IW'(NDIG - 1);
    assign nib  = snap[{idx, 2'b00} +: 4];

    // Walk from the top digit down: run stays high while every digit so far is zero,
    // so lz marks the leading zeros; digit 0 is never marked.
    always_comb begin
        bad = 1'b0;
        run = 1'b1;
        lz  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            bad   = bad | (bcd[4*i +: 4] > 4'd9);
            run   = run && snap[4*i +: 4] == 4'd0;
            lz[i] = run && i != 0;
        end
    end

    bcd7seg u_dec (.d(nib), .seg(pat));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            idx   <= '0;
            snap  <= '0;
            frame <= 1'b0;
            err   <= 1'b0;
            seg   <= {7{SEG_ACTIVE_LOW}};
            an    <= {NDIG{SEG_ACTIVE_LOW}};
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            idx   <= tick ? (last ? '0 : idx + 1'b1) : idx;
            frame <= tick && last;
            if (load) begin
                snap <= bcd;
                err  <= bad;
            end
            seg <= ((blank_lz && lz[idx]) ? SEG_OFF : pat) ^ {7{SEG_ACTIVE_LOW}};
            an  <= (NDIG'(1) << idx) ^ {NDIG{SEG_ACTIVE_LOW}};
        end
    end
endmodule
